// File: rtl/reg_file_mp_pkg.sv
// Helpers for the multi-port register file: write-port priority selection.
package reg_file_mp_pkg;

    // Upper bound on write ports handled by wr_select(); callers zero-extend their hit vector.
    localparam int unsigned MAX_WR_PORTS = 8;

    // One-hot of the highest-index set bit, so the highest write port wins a collision.
    function automatic logic [MAX_WR_PORTS-1:0] wr_select(input logic [MAX_WR_PORTS-1:0] hits);
        logic [MAX_WR_PORTS-1:0] sel;
        sel = '0;
        for (int i = 0; i < int'(MAX_WR_PORTS); i++) begin
            if (hits[i]) begin
                sel = MAX_WR_PORTS'(1) << i;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Shared RV32I datapath definitions: hardwired-zero register index and register index type.
package riscv_32i_defs_pkg;

    localparam int unsigned X0           = 0;
    localparam int unsigned RV_REG_IDX_W = 5;

    typedef logic [RV_REG_IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_mp_assert.sv
// Invariant checks bound into reg_file_mp: x0 reads zero, busy[0] never set, no busy on a bypass hit.
module reg_file_mp_assert #(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_RD_PORTS = 2,
    parameter  int unsigned NUM_WR_PORTS = 1,
    parameter  int unsigned BYPASS       = 1,
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] i_rd_reg,
    input  logic [NUM_RD_PORTS*XLEN-1:0]   i_rd_data,
    input  logic [NUM_RD_PORTS-1:0]        i_rd_busy,
    input  logic                           i_busy0,
    input  logic [NUM_WR_PORTS-1:0]        i_wr_en,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0] i_wr_reg
);

    logic [NUM_RD_PORTS-1:0] w_byp_hit;

    always_comb begin
        w_byp_hit = '0;
        for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
            for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
                if (i_wr_en[w] && (i_wr_reg[w*ADDR_W +: ADDR_W] == i_rd_reg[p*ADDR_W +: ADDR_W])) begin
                    w_byp_hit[p] = 1'b1;
                end
            end
        end
    end

    // Sampled mid-cycle, once combinational reads have settled.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (i_busy0 == 1'b0);
            for (int p = 0; p < int'(NUM_RD_PORTS); p++) begin
                if (i_rd_reg[p*ADDR_W +: ADDR_W] == '0) begin
                    assert ((i_rd_data[p*XLEN +: XLEN] == '0) && !i_rd_busy[p]);
                end
                if ((BYPASS != 0) && w_byp_hit[p]) begin
                    assert (!i_rd_busy[p]);
                end
            end
        end
    end

endmodule

bind reg_file_mp reg_file_mp_assert #(
    .XLEN         (XLEN),
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .BYPASS       (BYPASS)
) u_reg_file_mp_assert (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_reg  (rd_reg),
    .i_rd_data (rd_data),
    .i_rd_busy (rd_busy),
    .i_busy0   (w_busy[0]),
    .i_wr_en   (w_wr_en),
    .i_wr_reg  (wr_reg)
);

// File: rtl/reg_file_rd_port.sv
// One combinational read port: range check, write-bypass priority match and busy masking.
module reg_file_rd_port
    import riscv_32i_defs_pkg::*;
    import reg_file_mp_pkg::*;
#(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_WR_PORTS = 1,
    parameter  int unsigned BYPASS       = 1,
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic [ADDR_W-1:0]              i_rd_reg,
    input  logic [NUM_REGS*XLEN-1:0]       i_regs,
    input  logic [NUM_REGS-1:0]            i_busy,
    input  logic [NUM_WR_PORTS-1:0]        i_wr_en,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0] i_wr_reg,
    input  logic [NUM_WR_PORTS*XLEN-1:0]   i_wr_data,
    output logic [XLEN-1:0]                o_rd_data,
    output logic                           o_rd_busy
);

    logic                    w_valid;
    logic [XLEN-1:0]         w_stored;
    logic                    w_stored_busy;
    logic [NUM_WR_PORTS-1:0] w_hits;
    logic [NUM_WR_PORTS-1:0] w_sel;
    logic [XLEN-1:0]         w_byp_data;
    logic                    w_byp;

    // Match-based lookup so addresses beyond NUM_REGS simply find nothing.
    always_comb begin
        w_valid       = 1'b0;
        w_stored      = '0;
        w_stored_busy = 1'b0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (i_rd_reg == ADDR_W'(r)) begin
                w_valid       = (r != int'(X0));
                w_stored      = i_regs[r*XLEN +: XLEN];
                w_stored_busy = i_busy[r];
            end
        end
    end

    always_comb begin
        w_hits = '0;
        for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
            w_hits[w] = i_wr_en[w] && (i_wr_reg[w*ADDR_W +: ADDR_W] == i_rd_reg);
        end
    end

    assign w_sel = NUM_WR_PORTS'(wr_select(MAX_WR_PORTS'(w_hits)));

    always_comb begin
        w_byp_data = '0;
        for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
            if (w_sel[w]) begin
                w_byp_data = i_wr_data[w*XLEN +: XLEN];
            end
        end
    end

    assign w_byp     = (BYPASS != 0) && (|w_hits);
    assign o_rd_data = !w_valid ? '0 : (w_byp ? w_byp_data : w_stored);
    assign o_rd_busy = w_valid && !w_byp && w_stored_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write bypass and per-register busy scoreboard.
module reg_file_mp
    import riscv_32i_defs_pkg::*;
    import reg_file_mp_pkg::*;
#(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_RD_PORTS = 2,
    parameter  int unsigned NUM_WR_PORTS = 1,
    parameter  int unsigned BYPASS       = 1,
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_reg,
    output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
    output logic [NUM_RD_PORTS-1:0]        rd_busy,
    input  logic [NUM_WR_PORTS-1:0]        wr_en,
    input  logic [NUM_WR_PORTS*ADDR_W-1:0] wr_reg,
    input  logic [NUM_WR_PORTS*XLEN-1:0]   wr_data,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_reg
);

    logic [NUM_WR_PORTS-1:0]  w_wr_en;
    logic [NUM_REGS*XLEN-1:0] w_regs_flat;
    logic [NUM_REGS-1:0]      w_busy;

    // Gating with rst_n keeps bypassed data off rd_data while reset is held.
    assign w_wr_en = wr_en & {NUM_WR_PORTS{rst_n}};

    assign w_regs_flat[X0*XLEN +: XLEN] = '0;
    assign w_busy[X0]                   = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic [NUM_WR_PORTS-1:0] w_hits;
        logic [NUM_WR_PORTS-1:0] w_sel;
        logic [XLEN-1:0]         w_val;
        logic                    w_rsv;
        logic [XLEN-1:0]         r_data;
        logic                    r_busy;

        always_comb begin
            w_hits = '0;
            for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
                w_hits[w] = w_wr_en[w] && (wr_reg[w*ADDR_W +: ADDR_W] == ADDR_W'(g));
            end
        end

        assign w_sel = NUM_WR_PORTS'(wr_select(MAX_WR_PORTS'(w_hits)));

        always_comb begin
            w_val = '0;
            for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
                if (w_sel[w]) begin
                    w_val = wr_data[w*XLEN +: XLEN];
                end
            end
        end

        assign w_rsv = rsv_en && (rsv_reg == ADDR_W'(g));

        // A reserve on the same edge as a write belongs to a newer producer, so it wins.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
                r_busy <= 1'b0;
            end else begin
                if (|w_hits) begin
                    r_data <= w_val;
                end
                if (w_rsv) begin
                    r_busy <= 1'b1;
                end else if (|w_hits) begin
                    r_busy <= 1'b0;
                end
            end
        end

        assign w_regs_flat[g*XLEN +: XLEN] = r_data;
        assign w_busy[g]                   = r_busy;
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        reg_file_rd_port #(
            .XLEN         (XLEN),
            .NUM_REGS     (NUM_REGS),
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .BYPASS       (BYPASS)
        ) u_rd_port (
            .i_rd_reg  (rd_reg[p*ADDR_W +: ADDR_W]),
            .i_regs    (w_regs_flat),
            .i_busy    (w_busy),
            .i_wr_en   (w_wr_en),
            .i_wr_reg  (wr_reg),
            .i_wr_data (wr_data),
            .o_rd_data (rd_data[p*XLEN +: XLEN]),
            .o_rd_busy (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: 2R/2W builds with and without bypass, driven in lockstep against a reference model.
module tb_reg_file_mp;

    localparam int NR = 24;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  t_rd;
    logic [1:0]       t_wen;
    logic [1:0][4:0]  t_wreg;
    logic [1:0][31:0] t_wdata;
    logic             t_rsv_en;
    logic [4:0]       t_rsv_reg;
    logic [1:0][31:0] rdd_b, rdd_n;
    logic [1:0]       rbz_b, rbz_n;

    logic [31:0] m_regs [NR];
    bit          m_busy [NR];
    int          checks = 0;
    int          errors = 0;

    reg_file_mp #(.XLEN(32), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_reg(t_rd), .rd_data(rdd_b), .rd_busy(rbz_b),
        .wr_en(t_wen), .wr_reg(t_wreg), .wr_data(t_wdata), .rsv_en(t_rsv_en), .rsv_reg(t_rsv_reg));

    reg_file_mp #(.XLEN(32), .NUM_REGS(NR), .NUM_RD_PORTS(2), .NUM_WR_PORTS(2), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .rd_reg(t_rd), .rd_data(rdd_n), .rd_busy(rbz_n),
        .wr_en(t_wen), .wr_reg(t_wreg), .wr_data(t_wdata), .rsv_en(t_rsv_en), .rsv_reg(t_rsv_reg));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit addr_ok(input logic [4:0] a);
        return (a != '0) && (int'(a) < NR);
    endfunction

    // Expected read value: zero when invalid or in reset, else last same-cycle writer (bypass) or storage.
    function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] a);
        logic [31:0] v;
        if (!rst_n || !addr_ok(a)) return '0;
        v = m_regs[a];
        if (byp) for (int w = 0; w < 2; w++) if (t_wen[w] && t_wreg[w] == a) v = t_wdata[w];
        return v;
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] a);
        if (!rst_n || !addr_ok(a)) return 1'b0;
        if (byp) for (int w = 0; w < 2; w++) if (t_wen[w] && t_wreg[w] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        t_rd = '0; t_wen = '0; t_wreg = '0; t_wdata = '0; t_rsv_en = 1'b0; t_rsv_reg = '0;
    endtask

    // Advance one edge; the model applies writes (highest port last) then the reserve.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int w = 0; w < 2; w++) begin
                if (t_wen[w] && addr_ok(t_wreg[w])) begin
                    m_regs[t_wreg[w]] = t_wdata[w];
                    m_busy[t_wreg[w]] = 1'b0;
                end
            end
            if (t_rsv_en && addr_ok(t_rsv_reg)) m_busy[t_rsv_reg] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        model_clear();
        #1 rst_n = 1'b0;
        t_rd[0] = 5'd5; t_wen[0] = 1'b1; t_wreg[0] = 5'd5; t_wdata[0] = 32'hDEADBEEF;
        t_rsv_en = 1'b1; t_rsv_reg = 5'd5;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got; logic gb;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            gb  = d == 0 ? rbz_b[0] : rbz_n[0];
            checks++;
            if (got !== 32'h0 || gb !== 1'b0) begin
                errors++; $display("FAIL reset_hold dut%0d: data %h busy %b, want 0/0", d, got, gb);
            end
        end
        tick();
        rst_n = 1'b1;
        clear_inputs();
        t_wen[0] = 1'b1; t_wreg[0] = 5'd5; t_wdata[0] = 32'hDEADBEEF;
        tick();
        clear_inputs();
        t_rd[0] = 5'd5;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            checks++;
            if (got !== 32'hDEADBEEF) begin
                errors++; $display("FAIL reset_prewrite dut%0d: got %h want deadbeef", d, got);
            end
        end
        // Mid-cycle reset pulse with a live write to the same register.
        #2;
        t_wen[1] = 1'b1; t_wreg[1] = 5'd5; t_wdata[1] = 32'h12345678;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got; logic gb;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            gb  = d == 0 ? rbz_b[0] : rbz_n[0];
            checks++;
            if (got !== 32'h0 || gb !== 1'b0) begin
                errors++; $display("FAIL reset_midcycle dut%0d: data %h busy %b, want 0/0", d, got, gb);
            end
        end
        model_clear();
        #1 rst_n = 1'b1;
        clear_inputs();
        tick();
        t_rd[0] = 5'd5;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            checks++;
            if (got !== 32'h0) begin
                errors++; $display("FAIL reset_after dut%0d: got %h want 0", d, got);
            end
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        t_wen = 2'b11; t_wreg[0] = 5'd0; t_wreg[1] = 5'd0;
        t_wdata[0] = 32'hFFFFFFFF; t_wdata[1] = 32'hFFFFFFFF;
        t_rsv_en = 1'b1; t_rsv_reg = 5'd0;
        t_rd[0] = 5'd0;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            checks++;
            if (got !== 32'h0) begin
                errors++; $display("FAIL x0_bypass dut%0d: got %h want 0", d, got);
            end
        end
        tick();
        clear_inputs();
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] got; logic gb;
                got = d == 0 ? rdd_b[p] : rdd_n[p];
                gb  = d == 0 ? rbz_b[p] : rbz_n[p];
                checks++;
                if (got !== 32'h0 || gb !== 1'b0) begin
                    errors++; $display("FAIL x0_read dut%0d port%0d: data %h busy %b, want 0/0", d, p, got, gb);
                end
            end
        end
    endtask

    task automatic test_port_conflict();
        clear_inputs();
        t_wen = 2'b11; t_wreg[0] = 5'd7; t_wreg[1] = 5'd7;
        t_wdata[0] = 32'h11; t_wdata[1] = 32'h22;
        t_rd[1] = 5'd7;
        #2;
        checks++;
        if (rdd_b[1] !== 32'h22) begin
            errors++; $display("FAIL conflict_bypass: got %h want 00000022", rdd_b[1]);
        end
        checks++;
        if (rdd_n[1] !== 32'h0) begin
            errors++; $display("FAIL conflict_nobypass_old: got %h want 0", rdd_n[1]);
        end
        tick();
        clear_inputs();
        t_rd[0] = 5'd7; t_rd[1] = 5'd7;
        #2;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                logic [31:0] got;
                got = d == 0 ? rdd_b[p] : rdd_n[p];
                checks++;
                if (got !== 32'h22) begin
                    errors++; $display("FAIL conflict_stored dut%0d port%0d: got %h want 00000022", d, p, got);
                end
            end
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        t_wen[1] = 1'b1; t_wreg[1] = 5'd3; t_wdata[1] = 32'h0BADF00D;
        tick();
        clear_inputs();
        t_wen[0] = 1'b1; t_wreg[0] = 5'd3; t_wdata[0] = 32'hA5A5A5A5;
        t_rd[0] = 5'd3;
        #2;
        checks++;
        if (rdd_b[0] !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL bypass_same_cycle: got %h want a5a5a5a5", rdd_b[0]);
        end
        checks++;
        if (rdd_n[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL nobypass_same_cycle: got %h want 0badf00d", rdd_n[0]);
        end
        tick();
        clear_inputs();
        t_rd[0] = 5'd3;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] got;
            got = d == 0 ? rdd_b[0] : rdd_n[0];
            checks++;
            if (got !== 32'hA5A5A5A5) begin
                errors++; $display("FAIL bypass_after_edge dut%0d: got %h want a5a5a5a5", d, got);
            end
        end
    endtask

    task automatic test_scoreboard();
        logic [1:0] want_busy [5];
        // Expected busy for {BYPASS=0, BYPASS=1} at each observation point.
        want_busy[0] = 2'b00;   // reserve presented, before edge
        want_busy[1] = 2'b11;   // after reserve edge
        want_busy[2] = 2'b10;   // write presented: bypass masks busy, stored busy still set
        want_busy[3] = 2'b00;   // after write edge
        want_busy[4] = 2'b11;   // after reserve + write on same edge
        for (int s = 0; s < 5; s++) begin
            clear_inputs();
            t_rd[0] = 5'd9;
            case (s)
                0: begin t_rsv_en = 1'b1; t_rsv_reg = 5'd9; end
                2: begin t_wen[0] = 1'b1; t_wreg[0] = 5'd9; t_wdata[0] = 32'h99; end
                default: ;
            endcase
            #2;
            checks++;
            if ({rbz_n[0], rbz_b[0]} !== want_busy[s]) begin
                errors++; $display("FAIL scoreboard_step%0d: busy{n,b} %b want %b", s, {rbz_n[0], rbz_b[0]}, want_busy[s]);
            end
            case (s)
                1: begin t_rsv_en = 1'b1; t_rsv_reg = 5'd9; end
                3: begin t_rsv_en = 1'b1; t_rsv_reg = 5'd9;
                         t_wen[1] = 1'b1; t_wreg[1] = 5'd9; t_wdata[1] = 32'h999; end
                default: ;
            endcase
            if (s < 4) tick();
        end
        clear_inputs();
        t_wen[0] = 1'b1; t_wreg[0] = 5'd9; t_wdata[0] = 32'h9;
        tick();
        clear_inputs();
    endtask

    task automatic test_out_of_range();
        clear_inputs();
        t_wen = 2'b11; t_wreg[0] = 5'd24; t_wdata[0] = 32'hCAFE0024;
        t_wreg[1] = 5'd23; t_wdata[1] = 32'h00002323;
        t_rsv_en = 1'b1; t_rsv_reg = 5'd30;
        t_rd[0] = 5'd24; t_rd[1] = 5'd23;
        #2;
        checks++;
        if (rdd_b[0] !== 32'h0 || rdd_n[0] !== 32'h0 || rbz_b[0] !== 1'b0 || rbz_n[0] !== 1'b0) begin
            errors++; $display("FAIL oor_bypass: b %h n %h busy %b%b, want zeros", rdd_b[0], rdd_n[0], rbz_b[0], rbz_n[0]);
        end
        checks++;
        if (rdd_b[1] !== 32'h00002323) begin
            errors++; $display("FAIL top_reg_bypass: got %h want 00002323", rdd_b[1]);
        end
        tick();
        clear_inputs();
        t_rsv_en = 1'b1; t_rsv_reg = 5'd23;
        tick();
        clear_inputs();
        t_rd[0] = 5'd30; t_rd[1] = 5'd23;
        #2;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] g0, g1; logic b0, b1;
            g0 = d == 0 ? rdd_b[0] : rdd_n[0];
            g1 = d == 0 ? rdd_b[1] : rdd_n[1];
            b0 = d == 0 ? rbz_b[0] : rbz_n[0];
            b1 = d == 0 ? rbz_b[1] : rbz_n[1];
            checks++;
            if (g0 !== 32'h0 || b0 !== 1'b0 || g1 !== 32'h00002323 || b1 !== 1'b1) begin
                errors++; $display("FAIL range_edges dut%0d: x30 %h/%b x23 %h/%b, want 0/0 00002323/1", d, g0, b0, g1, b1);
            end
        end
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 99) < 88) return 5'($urandom_range(1, NR - 1));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic test_random();
        for (int it = 0; it < 1000; it++) begin
            for (int w = 0; w < 2; w++) begin
                t_wen[w]   = 1'($urandom_range(0, 1));
                t_wreg[w]  = rand_addr();
                t_wdata[w] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) t_wreg[1] = t_wreg[0];
            t_rsv_en  = 1'($urandom_range(0, 1));
            t_rsv_reg = ($urandom_range(0, 3) == 0) ? t_wreg[$urandom_range(0, 1)] : rand_addr();
            for (int p = 0; p < 2; p++) begin
                t_rd[p] = ($urandom_range(0, 2) == 0) ? t_wreg[$urandom_range(0, 1)] : rand_addr();
            end
            #2;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    logic [31:0] got, want; logic gb, wb;
                    got  = d == 0 ? rdd_b[p] : rdd_n[p];
                    gb   = d == 0 ? rbz_b[p] : rbz_n[p];
                    want = exp_data(d == 0, t_rd[p]);
                    wb   = exp_busy(d == 0, t_rd[p]);
                    checks++;
                    if (got !== want || gb !== wb) begin
                        errors++;
                        $display("FAIL random it%0d dut%0d port%0d addr %0d: data %h busy %b, want %h %b",
                                 it, d, p, t_rd[p], got, gb, want, wb);
                    end
                end
            end
            tick();
        end
        clear_inputs();
        for (int a = 0; a < 32; a++) begin
            t_rd[0] = 5'(a);
            t_rd[1] = 5'(31 - a);
            #2;
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    logic [31:0] got, want; logic gb, wb;
                    got  = d == 0 ? rdd_b[p] : rdd_n[p];
                    gb   = d == 0 ? rbz_b[p] : rbz_n[p];
                    want = exp_data(d == 0, t_rd[p]);
                    wb   = exp_busy(d == 0, t_rd[p]);
                    checks++;
                    if (got !== want || gb !== wb) begin
                        errors++;
                        $display("FAIL sweep dut%0d port%0d addr %0d: data %h busy %b, want %h %b",
                                 d, p, t_rd[p], got, gb, want, wb);
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_port_conflict();
        test_bypass();
        test_scoreboard();
        test_out_of_range();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
